// File: rtl/matrix_kxk_gen_pkg.sv
// Shared constants and helpers for the K x K neighbourhood window generator.
package matrix_pkg;

  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPL = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/matrix_kxk_gen_if.sv
// Pixel-in / window-out bundle of the window generator; the pixel source is the master.
interface matrix_kxk_gen_if #(
  parameter int DW = 8,
  parameter int K  = 3
);

  logic              in_valid;
  logic              in_sof;
  logic [DW-1:0]     in_data;
  logic              border_mode;
  logic              out_valid;
  logic              out_sof;
  logic [K*K*DW-1:0] win;

  modport master (
    output in_valid, in_sof, in_data, border_mode,
    input  out_valid, out_sof, win
  );

  modport slave (
    input  in_valid, in_sof, in_data, border_mode,
    output out_valid, out_sof, win
  );

endinterface

// File: rtl/matrix_kxk_gen_line_buffer_ram.sv
// One raster line of pixels: registered read, independent write, read-old-data on collision.
module line_buffer_ram
  import matrix_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 640
) (
  input  logic                    clk,
  input  logic                    rd_en_i,
  input  logic [clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DW-1:0]           rd_data_o,
  input  logic                    wr_en_i,
  input  logic [clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DW-1:0]           wr_data_i
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; stale contents are masked downstream.
  // NOTE: non-blocking read and write make a same-address collision return the old word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/matrix_kxk_gen.sv
// Streaming K x K window generator: line buffers feed a column-shift array, border masked on output.
module matrix_kxk_gen
  import matrix_pkg::*;
#(
  parameter int DW    = 8,
  parameter int K     = 3,
  parameter int IMG_W = 640
) (
  input  logic            clk,
  input  logic            rst_n,
  matrix_kxk_gen_if.slave bus
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(K);

  // Position of the next accepted pixel; y only needs to count rows seen up to K-1.
  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic          bm_q, bm_d, bm_cur;
  logic          accept;

  // Stage 1: the accepted pixel, its coordinates and line-buffer read data.
  logic          v1_q, sof1_q, bm1_q;
  logic [XW-1:0] x1_q;
  logic [YW-1:0] y1_q;
  logic [DW-1:0] data1_q;
  logic [DW-1:0] lb_rd [K-1];
  logic [DW-1:0] lb_wr [K-1];

  // Stage 2: the column-shift array and the registered window.
  logic [DW-1:0]     arr_q [K][K];
  logic [DW-1:0]     arr_d [K][K];
  logic [K-1:0]      x_lt, y_lt;
  logic [K*K*DW-1:0] win_d, win_q;
  logic              out_valid_q, out_sof_q;

  assign accept = bus.in_valid;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    px     = bus.in_sof ? '0 : x_q;
    py     = bus.in_sof ? '0 : y_q;
    bm_cur = bus.in_sof ? bus.border_mode : bm_q;
    x_d    = x_q;
    y_d    = y_q;
    bm_d   = bm_q;
    if (accept) begin
      bm_d = bm_cur;
      if (px == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (py == YW'(K - 1)) ? py : py + YW'(1);
      end else begin
        x_d = px + XW'(1);
        y_d = py;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      bm_q    <= BORDER_ZERO;
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      bm1_q   <= BORDER_ZERO;
      x1_q    <= '0;
      y1_q    <= '0;
      data1_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      bm_q <= bm_d;
      v1_q <= accept;
      if (accept) begin
        sof1_q  <= bus.in_sof;
        bm1_q   <= bm_cur;
        x1_q    <= px;
        y1_q    <= py;
        data1_q <= bus.in_data;
      end
    end
  end

  // The chain write trails its read by one pixel, so the old word of buffer i-1 is already registered.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_wr[i] = data1_q;
    end else begin : g_tail
      assign lb_wr[i] = lb_rd[i-1];
    end

    line_buffer_ram #(
      .DW    (DW),
      .DEPTH (IMG_W)
    ) u_ram (
      .clk       (clk),
      .rd_en_i   (accept),
      .rd_addr_i (px),
      .rd_data_o (lb_rd[i]),
      .wr_en_i   (v1_q),
      .wr_addr_i (x1_q),
      .wr_data_i (lb_wr[i])
    );
  end

  always_comb begin
    arr_d = arr_q;
    if (v1_q) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          arr_d[r][c] = arr_q[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        arr_d[r][K-1] = lb_rd[K-2-r];
      end
      arr_d[K-1][K-1] = data1_q;
    end
  end

  // Bit d is set when a tap d columns left of / d rows above the current pixel falls off the image.
  always_comb begin
    x_lt = '0;
    y_lt = '0;
    for (int d = 0; d < K; d++) begin
      x_lt[d] = (x1_q < XW'(d));
      y_lt[d] = (y1_q < YW'(d));
    end
  end

  always_comb begin
    logic [YW-1:0] rs;
    logic [YW-1:0] cs;
    win_d = '0;
    rs    = '0;
    cs    = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        rs = YW'(r);
        cs = YW'(c);
        // Replicate redirects an off-image tap to the column-0 / row-0 tap already in the array.
        if (x_lt[K-1-c]) cs = YW'(K - 1) - YW'(x1_q);
        if (y_lt[K-1-r]) rs = YW'(K - 1) - y1_q;
        if (bm1_q == BORDER_REPL) begin
          win_d[(r*K+c)*DW +: DW] = arr_d[rs][cs];
        end else if (x_lt[K-1-c] || y_lt[K-1-r]) begin
          win_d[(r*K+c)*DW +: DW] = '0;
        end else begin
          win_d[(r*K+c)*DW +: DW] = arr_d[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      win_q       <= '0;
      arr_q       <= '{default: '0};
    end else begin
      out_valid_q <= v1_q;
      out_sof_q   <= v1_q & sof1_q;
      if (v1_q) begin
        arr_q <= arr_d;
        win_q <= win_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.win       = win_q;

endmodule

// File: tb/tb_matrix_kxk_gen.sv
// Scoreboard bench for matrix_kxk_gen: a K=3 and a K=5 instance on 8-pixel lines, pixel = 8y+x+1.
module tb_matrix_kxk_gen;
  import matrix_pkg::*;

  typedef struct {
    int           due;
    bit           sof;
    logic [199:0] win;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_at_edge = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t         q3[$];
  exp_t         q5[$];
  exp_t         e3, e5;
  logic [199:0] last3 = '0;
  logic [199:0] last5 = '0;

  matrix_kxk_gen_if #(.DW(8), .K(3)) a3 ();
  matrix_kxk_gen_if #(.DW(8), .K(5)) a5 ();

  matrix_kxk_gen #(.DW(8), .K(3), .IMG_W(8)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(a3));
  matrix_kxk_gen #(.DW(8), .K(5), .IMG_W(8)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(a5));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests = n_tests + 1;
    n_fail  = n_fail + 1;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Window by definition: off-image taps are 0, or clamped to column 0 / row 0.
  function automatic logic [199:0] model_win(input int k, input int x, input int y, input bit mode);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < k; r++) begin
      for (int c = 0; c < k; c++) begin
        int row;
        int col;
        row = y - k + 1 + r;
        col = x - k + 1 + c;
        if ((row < 0 || col < 0) && mode == BORDER_ZERO) begin
          w[(r*k+c)*8 +: 8] = 8'd0;
        end else begin
          if (row < 0) row = 0;
          if (col < 0) col = 0;
          w[(r*k+c)*8 +: 8] = 8'(8 * row + col + 1);
        end
      end
    end
    return w;
  endfunction

  // Hand-computed golden windows (tap (2,2) is the leftmost byte).
  function automatic bit gold3(input int x, input int y, input bit mode, output logic [199:0] w);
    w = '0;
    gold3 = 1'b1;
    if (mode == BORDER_ZERO && x == 0 && y == 0)
      w[71:0] = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    else if (mode == BORDER_ZERO && x == 1 && y == 1)
      w[71:0] = {8'd10, 8'd9, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    else if (mode == BORDER_ZERO && x == 4 && y == 3)
      w[71:0] = {8'd29, 8'd28, 8'd27, 8'd21, 8'd20, 8'd19, 8'd13, 8'd12, 8'd11};
    else if (mode == BORDER_ZERO && x == 0 && y == 1)
      w[71:0] = {8'd9, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    else if (mode == BORDER_REPL && x == 1 && y == 0)
      w[71:0] = {8'd2, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1};
    else if (mode == BORDER_REPL && x == 0 && y == 2)
      w[71:0] = {8'd17, 8'd17, 8'd17, 8'd9, 8'd9, 8'd9, 8'd1, 8'd1, 8'd1};
    else
      gold3 = 1'b0;
  endfunction

  function automatic bit gold5(input int x, input int y, input bit mode, output logic [199:0] w);
    w = '0;
    gold5 = 1'b0;
    if (mode == BORDER_ZERO && x == 4 && y == 4) begin
      w = {8'd37, 8'd36, 8'd35, 8'd34, 8'd33, 8'd29, 8'd28, 8'd27, 8'd26, 8'd25,
           8'd21, 8'd20, 8'd19, 8'd18, 8'd17, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9,
           8'd5,  8'd4,  8'd3,  8'd2,  8'd1};
      gold5 = 1'b1;
    end
  endfunction

  function automatic logic [199:0] expect_win(input int k, input int x, input int y, input bit mode);
    logic [199:0] w;
    if (k == 3) begin
      if (gold3(x, y, mode, w)) return w;
    end else begin
      if (gold5(x, y, mode, w)) return w;
    end
    return model_win(k, x, y, mode);
  endfunction

  // Non-sof pixels carry the opposite border_mode: only the latched value may matter.
  task automatic send(input int k, input int x, input int y, input bit sof, input bit mode);
    exp_t e;
    @(negedge clk);
    a3.in_valid = 1'b0;
    a3.in_sof   = 1'b0;
    a5.in_valid = 1'b0;
    a5.in_sof   = 1'b0;
    e.due = cyc + 2;
    e.sof = sof;
    e.win = expect_win(k, x, y, mode);
    if (k == 3) begin
      a3.in_valid    = 1'b1;
      a3.in_sof      = sof;
      a3.in_data     = 8'(8 * y + x + 1);
      a3.border_mode = sof ? mode : ~mode;
      q3.push_back(e);
    end else begin
      a5.in_valid    = 1'b1;
      a5.in_sof      = sof;
      a5.in_data     = 8'(8 * y + x + 1);
      a5.border_mode = sof ? mode : ~mode;
      q5.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a3.in_valid = 1'b0;
      a3.in_sof   = 1'b0;
      a5.in_valid = 1'b0;
      a5.in_sof   = 1'b0;
    end
  endtask

  // bubbles: 0 = continuous, 1 = valid pattern 1,0,0,..., 2 = random 0..2 idle cycles.
  task automatic frame(input int k, input bit mode, input int npix, input int bubbles);
    for (int p = 0; p < npix; p++) begin
      send(k, p % 8, p / 8, p == 0, mode);
      if (bubbles == 1) idle(2);
      else if (bubbles == 2) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    rst_n       = 1'b0;
    a3.in_valid = 1'b0;
    a3.in_sof   = 1'b0;
    while (q3.size() > 0 && q3[$].due > cyc) void'(q3.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-line reset out_valid", a3.out_valid, 0);
    check("mid-line reset out_sof", a3.out_sof, 0);
    check("mid-line reset win", a3.win, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_at_edge) begin
      last3 = '0;
    end else if (a3.out_valid) begin
      if (q3.size() == 0) begin
        fail("k3 unexpected out_valid");
      end else begin
        e3 = q3.pop_front();
        check("k3 latency", cyc, e3.due);
        check("k3 out_sof", a3.out_sof, e3.sof);
        check("k3 win", a3.win, e3.win);
        last3 = e3.win;
      end
    end else begin
      if (q3.size() > 0 && q3[0].due <= cyc) begin
        e3 = q3.pop_front();
        fail("k3 missing window");
      end
      check("k3 win hold", a3.win, last3);
    end
  end

  always @(negedge clk) begin
    if (!rst_at_edge) begin
      last5 = '0;
    end else if (a5.out_valid) begin
      if (q5.size() == 0) begin
        fail("k5 unexpected out_valid");
      end else begin
        e5 = q5.pop_front();
        check("k5 latency", cyc, e5.due);
        check("k5 out_sof", a5.out_sof, e5.sof);
        check("k5 win", a5.win, e5.win);
        last5 = e5.win;
      end
    end else begin
      if (q5.size() > 0 && q5[0].due <= cyc) begin
        e5 = q5.pop_front();
        fail("k5 missing window");
      end
      check("k5 win hold", a5.win, last5);
    end
  end

  initial begin
    a3.in_valid = 1'b0; a3.in_sof = 1'b0; a3.in_data = '0; a3.border_mode = 1'b0;
    a5.in_valid = 1'b0; a5.in_sof = 1'b0; a5.in_data = '0; a5.border_mode = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset k3 out_valid", a3.out_valid, 0);
    check("reset k3 out_sof", a3.out_sof, 0);
    check("reset k3 win", a3.win, 0);
    check("reset k5 out_valid", a5.out_valid, 0);
    check("reset k5 win", a5.win, 0);

    frame(3, BORDER_ZERO, 32, 0);
    frame(3, BORDER_REPL, 32, 0);
    frame(3, BORDER_ZERO, 32, 1);
    frame(3, BORDER_REPL, 32, 2);
    frame(3, BORDER_ZERO, 13, 0);
    frame(3, BORDER_ZERO, 32, 0);
    frame(3, BORDER_ZERO, 10, 0);
    reset_mid();
    frame(3, BORDER_ZERO, 32, 0);
    idle(3);

    frame(5, BORDER_ZERO, 40, 0);
    frame(5, BORDER_REPL, 40, 1);
    idle(6);

    check("k3 scoreboard drained", q3.size(), 0);
    check("k5 scoreboard drained", q5.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
